// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and flag bundle for the registered ALU alu_seq.
// The optional multiply path is controlled by the ALU_MUL_EN macro.
package alu_seq_pkg;

  localparam logic [2:0] OPC_NEG = 3'b000;  // ~A + 1
  localparam logic [2:0] OPC_INC = 3'b001;  // A + 1
  localparam logic [2:0] OPC_ADC = 3'b010;  // A + B + C
  localparam logic [2:0] OPC_ADH = 3'b011;  // A + (B >> 1)
  localparam logic [2:0] OPC_AND = 3'b100;
  localparam logic [2:0] OPC_OR  = 3'b101;
  localparam logic [2:0] OPC_CAT = 3'b110;  // {A.lo, B.lo}
  localparam logic [2:0] OPC_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zer;
    logic neg;
    logic cry;
    logic ovf;
  } flags_t;

  // Two's-complement overflow of a + b: equal operand signs, different result sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier returning the low WIDTH bits of A*B after exactly WIDTH steps.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // The final step's sum is offered combinationally so the caller can register it on the same edge.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST_STEP);
  assign product_o = acc_d;

  // NOTE: non-blocking assignments for every flop so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        busy_q <= 1'b0;
      end
    end
  end

  // NOTE: datapath registers carry no reset; start_i always reloads them before busy_o qualifies them.
  always_ff @(posedge clk) begin
    if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and carry/overflow flags.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiply for opcode 111.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  input  logic [2:0]       opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             cry,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;

  state_e           state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] outw_q;
  flags_t           flags_q;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] wb_w;
  flags_t           wb_f;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  flags_t           res_f;

`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
`endif

  // All four arithmetic opcodes share one WIDTH+1-bit adder.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    add_a = inA;
    add_b = '0;
    add_c = 1'b0;
    unique case (opc)
      OPC_NEG: begin
        add_a = ~inA;
        add_c = 1'b1;
      end
      OPC_INC: add_c = 1'b1;
      OPC_ADC: begin
        add_b = inB;
        add_c = inC;
      end
      OPC_ADH: add_b = inB >> 1;
      default: ;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};

  always_comb begin
    res       = '0;
    res_f.cry = 1'b0;
    res_f.ovf = 1'b0;
    unique case (opc)
      OPC_NEG: begin
        res       = sum[WIDTH-1:0];
        res_f.cry = sum[WIDTH];
      end
      OPC_INC, OPC_ADC, OPC_ADH: begin
        res       = sum[WIDTH-1:0];
        res_f.cry = sum[WIDTH];
        res_f.ovf = add_ovf(add_a[WIDTH-1], add_b[WIDTH-1], sum[WIDTH-1]);
      end
      OPC_AND: res = inA & inB;
      OPC_OR:  res = inA | inB;
      OPC_CAT: res = {inA[HALF-1:0], inB[HALF-1:0]};
      default: res = '0;  // multiply without the multiplier built
    endcase
    res_f.zer = (res == '0);
    res_f.neg = res[WIDTH-1];
  end

`ifdef ALU_MUL_EN
  alu_shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .a_i      (inA),
    .b_i      (inB),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`endif

  assign in_ready = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    wb_w    = res;
    wb_f    = res_f;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (opc == OPC_MUL) begin
            state_d   = S_MUL;
            mul_start = 1'b1;
          end else begin
            state_d = S_DONE;
            load    = 1'b1;
          end
`else
          state_d = S_DONE;
          load    = 1'b1;
`endif
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          state_d   = S_DONE;
          load      = 1'b1;
          wb_w      = mul_prod;
          wb_f.zer  = (mul_prod == '0);
          wb_f.neg  = mul_prod[WIDTH-1];
          wb_f.cry  = 1'b0;
          wb_f.ovf  = 1'b0;
        end else if (!mul_busy) begin
          state_d = S_IDLE;  // multiplier lost its operation; never present a partial result
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      outw_q      <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == S_DONE);
      if (load) begin
        outw_q  <= wb_w;
        flags_q <= wb_f;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign outW      = outw_q;
  assign zer       = flags_q.zer;
  assign neg       = flags_q.neg;
  assign cry       = flags_q.cry;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed results, a monitor pops on each output transfer.
// Expectations for opcode 111 follow the ALU_MUL_EN macro.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH = 16;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] inA       = '0;
  logic [WIDTH-1:0] inB       = '0;
  logic             inC       = 1'b0;
  logic [2:0]       opc       = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] outW;
  logic             zer, neg, cry, ovf;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inA      (inA),
    .inB      (inB),
    .inC      (inC),
    .opc      (opc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .outW     (outW),
    .zer      (zer),
    .neg      (neg),
    .cry      (cry),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] w;
    logic [3:0]       f;        // {zer, neg, cry, ovf}
    int               exp_cyc;  // cycle count at which the result must first appear
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Offers one bundle (called at a negedge), waits boundedly for acceptance, leaves in_valid high.
  task automatic issue(input string name, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic c, input logic [WIDTH-1:0] w,
                       input logic [3:0] f, input int lat);
    exp_t e;
    int   waited = 0;
    in_valid = 1'b1;
    opc      = op;
    inA      = a;
    inB      = b;
    inC      = c;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, in_ready, 1);
      in_valid = 1'b0;
    end else begin
      e.name    = name;
      e.w       = w;
      e.f       = f;
      e.exp_cyc = cyc + lat;
      sb.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
  endtask

  logic mon_prev_valid = 1'b0;
  logic mon_prev_xfer  = 1'b0;
  logic mon_xfer;
  int   mon_arrival    = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mon_prev_valid = 1'b0;
        mon_prev_xfer  = 1'b0;
      end else begin
        if (out_valid && (!mon_prev_valid || mon_prev_xfer)) mon_arrival = cyc;
        mon_xfer = out_valid && out_ready;
        if (mon_xfer) begin
          if (sb.size() == 0) begin
            check("spurious_out", mon_xfer, 0);
          end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_w"}, outW, mon_e.w);
            check({mon_e.name, "_flags"}, {zer, neg, cry, ovf}, mon_e.f);
            check({mon_e.name, "_lat"}, mon_arrival, mon_e.exp_cyc);
          end
        end
        mon_prev_valid = out_valid;
        mon_prev_xfer  = mon_xfer;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, want summary before 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rose;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outW", outW, 0);
    check("rst_flags", {zer, neg, cry, ovf}, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single-cycle ops, back to back
    issue("adc_wrap",  OPC_ADC, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 4'b0010, 1);
    issue("adc_ovf",   OPC_ADC, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101, 1);
    issue("adc_negov", OPC_ADC, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1011, 1);
    issue("neg_one",   OPC_NEG, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 4'b0100, 1);
    issue("neg_zero",  OPC_NEG, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b1010, 1);
    issue("neg_min",   OPC_NEG, 16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b0100, 1);
    issue("cat",       OPC_CAT, 16'h12AB, 16'h34CD, 1'b0, 16'hABCD, 4'b0100, 1);
    issue("adh",       OPC_ADH, 16'h0001, 16'h0004, 1'b0, 16'h0003, 4'b0000, 1);
    issue("adh_odd",   OPC_ADH, 16'h0010, 16'h0003, 1'b1, 16'h0011, 4'b0000, 1);
    issue("adh_ovf",   OPC_ADH, 16'h7FFF, 16'hFFFF, 1'b0, 16'hFFFE, 4'b0101, 1);
    issue("and",       OPC_AND, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 4'b0000, 1);
    issue("inc_c_ign", OPC_INC, 16'h0005, 16'h0000, 1'b1, 16'h0006, 4'b0000, 1);
    issue("inc_wrap",  OPC_INC, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b1010, 1);
    issue("inc_ovf",   OPC_INC, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 4'b0101, 1);
    idle();
    drain("alu");

    // Backpressure: result held, new bundle refused until the consumer takes
    out_ready = 1'b0;
    issue("bp_or", OPC_OR, 16'h1200, 16'h0034, 1'b0, 16'h1234, 4'b0000, 1);
    opc = OPC_AND;
    inA = 16'hFFFF;
    inB = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_w", outW, 16'h1234);
      check("bp_hold_flags", {zer, neg, cry, ovf}, 0);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    issue("bp_and", OPC_AND, 16'hFFFF, 16'h00FF, 1'b0, 16'h00FF, 4'b0000, 1);
    idle();
    drain("bp");

    // Multiply
`ifdef ALU_MUL_EN
    issue("mul", OPC_MUL, 16'h0123, 16'h0010, 1'b0, 16'h1230, 4'b0000, WIDTH + 1);
`else
    issue("mul", OPC_MUL, 16'h0123, 16'h0010, 1'b0, 16'h0000, 4'b1000, 1);
`endif
    idle();
    drain("mul");

    // Reset in the fifth multiply cycle discards the operation
`ifdef ALU_MUL_EN
    issue("rst_mul", OPC_MUL, 16'h0123, 16'h0010, 1'b0, 16'h1230, 4'b0000, WIDTH + 1);
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mul_busy_valid", out_valid, 0);
      check("mul_busy_in_ready", in_ready, 0);
      @(negedge clk);
    end
`else
    issue("rst_mul", OPC_MUL, 16'h0123, 16'h0010, 1'b0, 16'h0000, 4'b1000, 1);
    idle();
    repeat (4) @(negedge clk);
`endif
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_outW", outW, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    rose = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (out_valid) rose++;
    end
    check("mid_rst_no_result", rose, 0);
    @(negedge clk);
    issue("or_after_rst", OPC_OR, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 4'b0100, 1);
    idle();
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
